microcode_sequencer: RTL
========================

# microcode_sequencer

- Parametrised successor to the fixed state-to-control-word decoder.
- Owns its micro-program counter (upc) and issues a registered control word each cycle from a writable microcode store.
- Next-address selection per microword: increment, jump, opcode dispatch or halt. Dispatch targets come from a writable table.
- Sits between the instruction register (opcode) and the datapath/memory control lines. It replaces the external state machine plus the hard-coded decoder.

## Interface
- CW_W, 20: control word width.
- SA_W, 6: micro-address width; store depth is 2**SA_W.
- OP_W, 4: opcode width; dispatch table depth is 2**OP_W.
- FETCH_ADDR, 1: first microword executed after start. Must be non-zero.
- Microword width MW = CW_W+SA_W+3, laid out LSB first:
  - [CW_W-1:0] control.
  - [CW_W+SA_W-1:CW_W] next_addr.
  - next 2 bits seq: 0 = NEXT, 1 = JUMP, 2 = DISPATCH, 3 = HALT.
  - MSB wait.
- clock, input, 1: sole clock, rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- start, input, 1: begin execution at FETCH_ADDR.
- abort, input, 1: return to idle immediately.
- opcode, input, OP_W: sampled only in cycles whose microword seq is DISPATCH.
- mem_ready, input, 1: completes a wait microword.
- wr_en, input, 1: store write strobe.
- wr_sel, input, 1: 0 = microword store, 1 = dispatch table.
- wr_addr, input, SA_W: write address; the dispatch table uses the low OP_W bits.
- wr_data, input, MW: write data; the dispatch table uses the low SA_W bits.
- control_out, output, CW_W: registered control word.
- state, output, SA_W: current upc; 0 when idle.
- busy, output, 1: executing.
- done, output, 1: one-cycle pulse on HALT.
- wr_err, output, 1: one-cycle pulse when a write is rejected.

## Operation
- Reset (async, reset_n=0):
  - upc=0, control_out=0, busy=0, done=0, wr_err=0.
  - Every dispatch entry = FETCH_ADDR.
  - Microword store is not reset; contents are undefined until written.
- Idle (busy=0):
  - control_out<=0 every edge; upc held at 0.
  - start=1 -> upc<=FETCH_ADDR, busy<=1.
- Run (busy=1), each edge with W = store[upc]:
  - control_out <= W.control.
  - Next upc per W.seq:
    - NEXT: upc+1, modulo 2**SA_W (wraps from max to 0 and keeps running).
    - JUMP: W.next_addr.
    - DISPATCH: dispatch[opcode].
    - HALT: upc<=0, busy<=0, done<=1.
  - Wait bit set and mem_ready=0: upc held, control_out re-issues W.control, seq action deferred. A HALT or DISPATCH with wait set acts only in the cycle mem_ready=1.
- abort=1 while busy: upc<=0, busy<=0, control_out<=0, no done. Abort has priority over wait, HALT and start. Abort while idle has no effect.
- start while busy: ignored.
- Writes:
  - Accepted only when busy=0, committed at the edge.
  - wr_en while busy: write dropped, wr_err<=1 for one cycle.
  - Same-edge start and write while idle: write commits; the first fetch read (next cycle) sees the new data.
- Reads of the microword store are combinational from upc. A registered store read is permitted only if control_out timing below is preserved.

## Timing
- start sampled at edge k:
  - busy=1 and state=FETCH_ADDR after edge k.
  - control_out = store[FETCH_ADDR].control after edge k+1.
- control_out always lags state by exactly one cycle.
- HALT word at upc h, executed at edge k:
  - After edge k: control_out = store[h].control, done=1, busy=0, state=0.
  - After edge k+1: control_out=0, done=0.
- Wait: each mem_ready=0 cycle adds one cycle. mem_ready=1 in the same cycle as the wait word gives no stall.
- Dispatch: opcode is sampled at the same edge that loads the target; no extra cycle.
- reset_n deassertion: first start is honoured at the first rising edge after deassertion.

## Configuration
- MICROSEQ_WAIT_EN defined: wait bit and mem_ready behave as above.
- Undefined: the wait bit is ignored, mem_ready is unused, and every microword completes in one cycle. The microword layout and MW are unchanged.

## Test plan
- Reset with no program: control_out=0, state=0, busy=0, done=0. Dispatch entry 5 reads back through dispatch as FETCH_ADDR=1.
- Program store[1]={ctrl 0x21080, NEXT}, [2]={0x20040, DISPATCH}, dispatch[3]=7, [7]={0x0040D, HALT}; opcode=3; pulse start:
  - state sequence 1,2,7,0.
  - control_out sequence 0x21080, 0x20040, 0x0040D, 0 (one cycle later than state).
  - done high for one cycle.
- store[1]={0x09020, wait, NEXT}, mem_ready low for 3 cycles: state stays 1 for 4 cycles, control_out shows 0x09020 repeatedly, then advances to 2.
- store[63]={NEXT}, JUMP into 63: upc wraps to 0 and keeps running with busy=1. store[0]={HALT} ends the run there.
- abort asserted while waiting: next edge gives busy=0, state=0, control_out=0, done never pulses.
- wr_en during run: wr_err pulses once and the target word is unchanged on re-run. With MICROSEQ_WAIT_EN undefined, the wait test advances without stalling.

Source files
------------

// File: rtl/microcode_sequencer.sv
// microcode_sequencer: writable-microstore sequencer issuing one registered control word per cycle.
// Optional feature: define MICROSEQ_WAIT_EN to let the microword wait bit stall on mem_ready.
module microcode_sequencer #(
  parameter int CW_W       = 20,
  parameter int SA_W       = 6,
  parameter int OP_W       = 4,
  parameter int FETCH_ADDR = 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [OP_W-1:0]      opcode,
  input  logic                 mem_ready,
  input  logic                 wr_en,
  input  logic                 wr_sel,
  input  logic [SA_W-1:0]      wr_addr,
  input  logic [CW_W+SA_W+2:0] wr_data,
  output logic [CW_W-1:0]      control_out,
  output logic [SA_W-1:0]      state,
  output logic                 busy,
  output logic                 done,
  output logic                 wr_err
);
  localparam int          MW     = CW_W + SA_W + 3;
  localparam int unsigned DEPTH  = 2**SA_W;
  localparam int unsigned ODEPTH = 2**OP_W;
  localparam logic [SA_W-1:0] FETCH = SA_W'(FETCH_ADDR);

  typedef enum logic [1:0] {SEQ_NEXT, SEQ_JUMP, SEQ_DISPATCH, SEQ_HALT} seq_e;
  typedef enum logic {IDLE, RUN} fsm_e;

  fsm_e            cur, nxt;
  logic [MW-1:0]   store    [DEPTH];
  logic [SA_W-1:0] dispatch [ODEPTH];
  logic [SA_W-1:0] upc, upc_n;
  logic [CW_W-1:0] ctrl_n;
  logic            done_n, err_n, stall, wr_ok;
  logic [MW-1:0]   word;
  logic [CW_W-1:0] w_ctrl;
  logic [SA_W-1:0] w_next;
  seq_e            w_seq;
  logic            w_wait;

  assign word   = store[upc];
  assign w_ctrl = word[CW_W-1:0];
  assign w_next = word[CW_W+SA_W-1:CW_W];
  assign w_seq  = seq_e'(word[MW-2:MW-3]);
  assign w_wait = word[MW-1];
  assign wr_ok  = wr_en && (cur == IDLE);

`ifdef MICROSEQ_WAIT_EN
  assign stall = w_wait & ~mem_ready;
`else
  logic unused_wait;
  assign stall       = 1'b0;
  assign unused_wait = w_wait ^ mem_ready;
`endif

  always_comb begin
    nxt    = cur;
    upc_n  = upc;
    ctrl_n = '0;
    done_n = 1'b0;
    err_n  = 1'b0;
    unique case (cur)
      IDLE: begin
        if (start) begin
          nxt   = RUN;
          upc_n = FETCH;
        end
      end
      RUN: begin
        err_n = wr_en;
        if (abort) begin
          nxt   = IDLE;
          upc_n = '0;
        end else begin
          // a stalled word keeps re-issuing its control field with the seq action deferred
          ctrl_n = w_ctrl;
          if (!stall) begin
            unique case (w_seq)
              SEQ_NEXT:     upc_n = upc + 1'b1;
              SEQ_JUMP:     upc_n = w_next;
              SEQ_DISPATCH: upc_n = dispatch[opcode];
              SEQ_HALT: begin
                nxt    = IDLE;
                upc_n  = '0;
                done_n = 1'b1;
              end
            endcase
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cur         <= IDLE;
      upc         <= '0;
      control_out <= '0;
      done        <= 1'b0;
      wr_err      <= 1'b0;
      for (int unsigned i = 0; i < ODEPTH; i++) dispatch[i] <= FETCH;
    end else begin
      cur         <= nxt;
      upc         <= upc_n;
      control_out <= ctrl_n;
      done        <= done_n;
      wr_err      <= err_n;
      if (wr_ok && wr_sel) dispatch[wr_addr[OP_W-1:0]] <= wr_data[SA_W-1:0];
    end
  end

  // microword store is deliberately not reset
  always_ff @(posedge clock) begin
    if (wr_ok && !wr_sel) store[wr_addr] <= wr_data;
  end

  assign state = upc;
  assign busy  = (cur == RUN);
endmodule
